fetch_bcache: RTL and testbench
===============================

FETCH_BCACHE -- requirements
Module: fetch_bcache

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clock  input  1  single clock; all state SHALL update on the negative edge, matching the pipeline register walls.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it (0) SHALL clear state immediately, independent of clock.
REQ-004 enable_fetch  input  1  global advance enable; when 0, all state SHALL hold.
REQ-005 do_hazard_pc  input  1  stall request; when 1, the PC SHALL hold.
REQ-006 do_redirect  input  1  redirect request (branch/jump resolved or mispredict recovery).
REQ-007 redirect_pc  input  32  target PC for a redirect.
REQ-008 update_valid  input  1  branch-resolution update strobe.
REQ-009 update_pc  input  32  PC of the resolved branch.
REQ-010 update_target  input  32  resolved branch target.
REQ-011 update_taken  input  1  resolved direction, 1 = taken.
REQ-012 oF_current_pc  output  32  registered fetch PC; drives instruction memory address and the REG1 current_pc input.
REQ-013 oF_do_hit_bcache  output  1  combinational; the current PC matches a valid entry.
REQ-014 oF_do_bcache  output  1  combinational; hit and the entry's counter is >= 2 (predicted taken).
REQ-015 oF_bcache_opc  output  32  combinational; oF_current_pc+4 (fall-through recovery PC) when oF_do_bcache=1, else 0.

Function
REQ-016 Branch cache SHALL have 4 fully-associative entries; each entry holds valid(1), tag(30) = pc[31:2], target(32) and a 2-bit saturating counter.
REQ-017 Lookup SHALL compare oF_current_pc[31:2] against all valid tags; at most one entry matches, because allocation only occurs on a miss.
REQ-018 Next-PC priority: reset > enable_fetch=0 (hold) > do_redirect (redirect_pc) > do_hazard_pc (hold) > oF_do_bcache (hit target) > oF_current_pc+4.
REQ-019 PC+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-020 When do_redirect and do_hazard_pc are both 1, the redirect SHALL win.
REQ-021 Update on an existing entry (tag = update_pc[31:2]):
- update_taken=1: counter increments, saturating at 3; target is overwritten with update_target.
- update_taken=0: counter decrements, saturating at 0; the entry stays valid.
REQ-022 Update miss with update_taken=1: allocate at the victim pointer with valid=1, tag, target and counter=2; the victim pointer then increments 0-1-2-3-0.
REQ-023 Update miss with update_taken=0: no allocation, and the pointer holds.
REQ-024 Updates SHALL apply only when enable_fetch=1; they are independent of do_hazard_pc and do_redirect.
REQ-025 Lookup and update in the same edge: the lookup SHALL use pre-update state, and the new state is visible from the next cycle.
REQ-026 Lookup outputs SHALL change only with oF_current_pc or cache state; there is no combinational path from update_* or redirect inputs to outputs.

Reset
REQ-027 On reset=0:
- oF_current_pc = RESET_PC.
- All valid bits, tags, targets and counters = 0.
- Victim pointer = 0.
- Hence oF_do_hit_bcache = 0, oF_do_bcache = 0 and oF_bcache_opc = 0.
REQ-028 Reset asserted mid-operation SHALL discard pending updates and redirects; after release, the first negedge with enable_fetch=1 SHALL advance to RESET_PC+4.

Verification
REQ-029 Reset release, enable_fetch=1, no events, 3 negedges -> oF_current_pc = 0, 4, 8, 12; hit = 0 throughout.
REQ-030 Update (pc=0x40, target=0x100, taken=1), then redirect to 0x40 -> at pc 0x40: hit=1, do_bcache=1, bcache_opc=0x44; next PC = 0x100.
REQ-031 Two not-taken updates on pc 0x40 (counter 2→1→0) -> at pc 0x40: hit=1, do_bcache=0, bcache_opc=0; next PC = 0x44. A third not-taken update leaves the counter at 0.
REQ-032 Five taken-update misses (pc 0x10, 0x20, 0x30, 0x40, 0x50) -> the 0x50 entry replaces the 0x10 entry; lookups at 0x10 miss and 0x20 hit; pointer = 1.
REQ-033 do_redirect=1 (0x200) with do_hazard_pc=1 -> PC = 0x200. With only do_hazard_pc=1 -> PC holds. With enable_fetch=0 plus a redirect and a taken update -> PC and cache unchanged.
REQ-034 PC at 0xFFFF_FFFC, no hit -> next PC = 0x0. Reset asserted between edges -> oF_current_pc = RESET_PC immediately, without a clock edge.

Source files
------------

// File: rtl/fetch_bcache.sv
// Fetch-stage PC register with a 4-entry fully-associative branch cache.
// State advances on the falling clock edge to line up with the pipeline
// register walls; reset is asynchronous and active-low.
//
// Ports:
//   clock, reset                 falling-edge clock, async active-low reset
//   enable_fetch                 global advance enable (0 = hold everything)
//   do_hazard_pc                 stall request, PC holds
//   do_redirect, redirect_pc     redirect request and its target
//   update_valid/pc/target/taken branch-resolution update
//   oF_current_pc                registered fetch PC
//   oF_do_hit_bcache             current PC hits a valid entry (comb)
//   oF_do_bcache                 hit with counter >= 2, predicted taken (comb)
//   oF_bcache_opc                fall-through PC when predicted taken, else 0 (comb)
module fetch_bcache #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_fetch,
   input  logic        do_hazard_pc,
   input  logic        do_redirect,
   input  logic [31:0] redirect_pc,
   input  logic        update_valid,
   input  logic [31:0] update_pc,
   input  logic [31:0] update_target,
   input  logic        update_taken,
   output logic [31:0] oF_current_pc,
   output logic        oF_do_hit_bcache,
   output logic        oF_do_bcache,
   output logic [31:0] oF_bcache_opc
);

   localparam int unsigned NUM_ENTRIES = 4;
   localparam int unsigned IDX_W       = 2;
   localparam int unsigned TAG_W       = 30;
   localparam int unsigned PC_W        = 32;
   localparam int unsigned CNT_W       = 2;

   logic             entryValid  [NUM_ENTRIES];
   logic [TAG_W-1:0] entryTag    [NUM_ENTRIES];
   logic [PC_W-1:0]  entryTarget [NUM_ENTRIES];
   logic [CNT_W-1:0] entryCount  [NUM_ENTRIES];
   logic [IDX_W-1:0] victimPtr;

   logic             lookHit;
   logic [IDX_W-1:0] lookWay;
   logic             updHit;
   logic [IDX_W-1:0] updWay;
   logic [CNT_W-1:0] updCountInc;
   logic [CNT_W-1:0] updCountDec;
   logic [PC_W-1:0]  pcPlus4;
   logic [PC_W-1:0]  nextPc;

   // Lookup on the registered PC; allocation only on a miss keeps tags unique.
   always_comb begin
      lookHit = 1'b0;
      lookWay = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (entryValid[i] && (entryTag[i] == oF_current_pc[PC_W-1:2])) begin
            lookHit = 1'b1;
            lookWay = IDX_W'(i);
         end
      end
   end

   // Match for the resolution update.
   always_comb begin
      updHit = 1'b0;
      updWay = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (entryValid[i] && (entryTag[i] == update_pc[PC_W-1:2])) begin
            updHit = 1'b1;
            updWay = IDX_W'(i);
         end
      end
   end

   // Saturating counter neighbours of the updated entry.
   always_comb begin
      updCountInc = entryCount[updWay];
      updCountDec = entryCount[updWay];
      if (entryCount[updWay] != 2'd3) updCountInc = entryCount[updWay] + 2'd1;
      if (entryCount[updWay] != 2'd0) updCountDec = entryCount[updWay] - 2'd1;
   end

   assign pcPlus4          = oF_current_pc + 32'd4;
   assign oF_do_hit_bcache = lookHit;
   assign oF_do_bcache     = lookHit & entryCount[lookWay][1];
   assign oF_bcache_opc    = oF_do_bcache ? pcPlus4 : '0;

   // Next-PC priority: redirect > hazard hold > predicted target > sequential.
   always_comb begin
      nextPc = pcPlus4;
      if (do_redirect)       nextPc = redirect_pc;
      else if (do_hazard_pc) nextPc = oF_current_pc;
      else if (oF_do_bcache) nextPc = entryTarget[lookWay];
   end

   // PC and cache state; updates ride the same enable as the PC.
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         oF_current_pc <= RESET_PC;
         victimPtr     <= '0;
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            entryValid[i]  <= 1'b0;
            entryTag[i]    <= '0;
            entryTarget[i] <= '0;
            entryCount[i]  <= '0;
         end
      end else if (enable_fetch) begin
         oF_current_pc <= nextPc;
         if (update_valid) begin
            if (updHit) begin
               if (update_taken) begin
                  entryCount[updWay]  <= updCountInc;
                  entryTarget[updWay] <= update_target;
               end else begin
                  entryCount[updWay]  <= updCountDec;
               end
            end else if (update_taken) begin
               entryValid[victimPtr]  <= 1'b1;
               entryTag[victimPtr]    <= update_pc[PC_W-1:2];
               entryTarget[victimPtr] <= update_target;
               entryCount[victimPtr]  <= 2'd2;
               victimPtr              <= victimPtr + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_bcache.sv
// Bench for fetch_bcache: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_fetch_bcache;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable_fetch = 1'b0;
   logic        do_hazard_pc = 1'b0;
   logic        do_redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        update_valid = 1'b0;
   logic [31:0] update_pc = '0;
   logic [31:0] update_target = '0;
   logic        update_taken = 1'b0;
   logic [31:0] oF_current_pc;
   logic        oF_do_hit_bcache;
   logic        oF_do_bcache;
   logic [31:0] oF_bcache_opc;

   int vectors = 0;
   int miscompares = 0;

   fetch_bcache #(.RESET_PC(RESET_PC)) dut (
      .clock(clock), .reset(reset), .enable_fetch(enable_fetch),
      .do_hazard_pc(do_hazard_pc), .do_redirect(do_redirect),
      .redirect_pc(redirect_pc), .update_valid(update_valid),
      .update_pc(update_pc), .update_target(update_target),
      .update_taken(update_taken), .oF_current_pc(oF_current_pc),
      .oF_do_hit_bcache(oF_do_hit_bcache), .oF_do_bcache(oF_do_bcache),
      .oF_bcache_opc(oF_bcache_opc));

   always #5 clock = ~clock;

   // Model: entries kept in allocation order; round-robin victim == oldest.
   typedef struct {
      logic [29:0] tag;
      logic [31:0] target;
      int          cnt;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mPc = RESET_PC;

   function automatic int findIdx(logic [29:0] t);
      foreach (mq[i]) if (mq[i].tag == t) return i;
      return -1;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clock or negedge reset) begin : model
      int k;
      int u;
      logic [31:0] nxt;
      ent_t e;
      if (!reset) begin
         mq.delete();
         mPc = RESET_PC;
      end else if (enable_fetch) begin
         k = findIdx(mPc[31:2]);
         if (do_redirect)                  nxt = redirect_pc;
         else if (do_hazard_pc)            nxt = mPc;
         else if (k >= 0 && mq[k].cnt >= 2) nxt = mq[k].target;
         else                              nxt = mPc + 32'd4;
         if (update_valid) begin
            u = findIdx(update_pc[31:2]);
            if (u >= 0) begin
               if (update_taken) begin
                  mq[u].cnt    = (mq[u].cnt >= 3) ? 3 : mq[u].cnt + 1;
                  mq[u].target = update_target;
               end else begin
                  mq[u].cnt = (mq[u].cnt <= 0) ? 0 : mq[u].cnt - 1;
               end
            end else if (update_taken) begin
               if (mq.size() == 4) void'(mq.pop_front());
               e.tag = update_pc[31:2];
               e.target = update_target;
               e.cnt = 2;
               mq.push_back(e);
            end
         end
         mPc = nxt;
      end
   end

   // Per-cycle compare, on the edge opposite the state edge.
   always @(posedge clock) begin : compare
      int k;
      logic eh, ed;
      if (reset) begin
         k  = findIdx(mPc[31:2]);
         eh = (k >= 0);
         ed = eh && (mq[k].cnt >= 2);
         check("pc",  oF_current_pc, mPc);
         check("hit", 32'(oF_do_hit_bcache), 32'(eh));
         check("dob", 32'(oF_do_bcache), 32'(ed));
         check("opc", oF_bcache_opc, ed ? mPc + 32'd4 : 32'd0);
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic idle();
      do_hazard_pc = 0; do_redirect = 0; update_valid = 0; update_taken = 0;
   endtask

   task automatic upd(logic [31:0] pc, logic [31:0] tgt, logic tk);
      update_valid = 1; update_pc = pc; update_target = tgt; update_taken = tk;
   endtask

   task automatic redir(logic [31:0] pc);
      do_redirect = 1; redirect_pc = pc;
   endtask

   task automatic pulseReset();
      #1 reset = 0;
      #1;
      check("rst_pc_immediate", oF_current_pc, RESET_PC);
      check("rst_hit", 32'(oF_do_hit_bcache), 32'd0);
      reset = 1;
   endtask

   initial begin
      #2 reset = 0;
      #10;
      check("reset_pc", oF_current_pc, RESET_PC);
      check("reset_hit", 32'(oF_do_hit_bcache), 32'd0);
      check("reset_opc", oF_bcache_opc, 32'd0);
      reset = 1; enable_fetch = 1;

      // Sequential fetch from reset.
      tick(); check("seq1", oF_current_pc, 32'd4);
      tick(); check("seq2", oF_current_pc, 32'd8);
      tick(); check("seq3", oF_current_pc, 32'd12);
      check("seq_hit", 32'(oF_do_hit_bcache), 32'd0);

      // Taken allocation, then redirect onto it.
      upd(32'h40, 32'h100, 1); tick(); idle();
      redir(32'h40); tick(); idle();
      check("alloc_hit", 32'(oF_do_hit_bcache), 32'd1);
      check("alloc_dob", 32'(oF_do_bcache), 32'd1);
      check("alloc_opc", oF_bcache_opc, 32'h44);
      tick(); check("alloc_next", oF_current_pc, 32'h100);

      // Counter 2->1->0: still a hit, predicted not taken.
      upd(32'h40, 32'h0, 0); tick(); tick(); idle();
      redir(32'h40); tick(); idle();
      check("nt_hit", 32'(oF_do_hit_bcache), 32'd1);
      check("nt_dob", 32'(oF_do_bcache), 32'd0);
      check("nt_opc", oF_bcache_opc, 32'd0);
      tick(); check("nt_next", oF_current_pc, 32'h44);
      // Third not-taken saturates at 0; one taken makes 1, still not taken.
      upd(32'h40, 32'h0, 0); tick(); upd(32'h40, 32'h100, 1); tick(); idle();
      redir(32'h40); tick(); idle();
      check("sat0_dob", 32'(oF_do_bcache), 32'd0);

      // Five allocations: 0x50 evicts 0x10; next victim is slot 1 (0x20).
      pulseReset();
      for (int i = 1; i <= 5; i++) begin
         upd(32'(i * 16), 32'h1000 + 32'(i * 16), 1); tick();
      end
      idle();
      redir(32'h10); tick(); idle(); check("evict_10", 32'(oF_do_hit_bcache), 32'd0);
      redir(32'h20); tick(); idle(); check("keep_20", 32'(oF_do_hit_bcache), 32'd1);
      redir(32'h50); tick(); idle(); check("new_50", 32'(oF_do_hit_bcache), 32'd1);
      upd(32'h60, 32'h2000, 1); tick(); idle();
      redir(32'h20); tick(); idle(); check("ptr1_20", 32'(oF_do_hit_bcache), 32'd0);
      redir(32'h30); tick(); idle(); check("ptr1_30", 32'(oF_do_hit_bcache), 32'd1);

      // Redirect beats hazard; hazard holds; disable freezes everything.
      redir(32'h200); do_hazard_pc = 1; tick(); idle();
      check("redir_hz", oF_current_pc, 32'h200);
      do_hazard_pc = 1; tick(); idle();
      check("hazard_hold", oF_current_pc, 32'h200);
      enable_fetch = 0; redir(32'h300); upd(32'h200, 32'h500, 1); tick();
      check("dis_pc", oF_current_pc, 32'h200);
      check("dis_hit", 32'(oF_do_hit_bcache), 32'd0);
      idle(); enable_fetch = 1; tick();
      check("dis_after", oF_current_pc, 32'h204);

      // PC wrap.
      redir(32'hFFFF_FFFC); tick(); idle();
      check("wrap_hit", 32'(oF_do_hit_bcache), 32'd0);
      tick(); check("wrap", oF_current_pc, 32'h0);

      // Reset mid-operation discards pending redirect/update.
      upd(32'h0, 32'h800, 1); redir(32'h900);
      #1 reset = 0;
      #1 check("mid_rst_pc", oF_current_pc, RESET_PC);
      tick(); idle(); reset = 1;
      check("mid_rst_hold", oF_current_pc, RESET_PC);
      check("mid_rst_hit", 32'(oF_do_hit_bcache), 32'd0);
      tick(); check("mid_rst_next", oF_current_pc, RESET_PC + 32'd4);

      // Randomized traffic over a small address range to force reuse.
      for (int n = 0; n < 600; n++) begin
         enable_fetch  = ($urandom_range(0, 9) != 0);
         do_hazard_pc  = ($urandom_range(0, 4) == 0);
         do_redirect   = ($urandom_range(0, 6) == 0);
         redirect_pc   = 32'($urandom_range(0, 31)) << 2;
         update_valid  = ($urandom_range(0, 1) == 1);
         update_pc     = 32'($urandom_range(0, 31)) << 2;
         update_target = 32'($urandom_range(0, 31)) << 2;
         update_taken  = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 99) == 0) pulseReset();
         tick();
      end
      idle(); enable_fetch = 1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
